// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// op_sat exists only when ADDSUB_SATURATE_EN is defined.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             cin;
`ifdef ADDSUB_SATURATE_EN
  logic             op_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

`ifdef ADDSUB_SATURATE_EN
  modport master (
    output in_valid, a, b, op_sub, cin, op_sat, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, op_sub, cin, op_sat, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b, op_sub, cin, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, op_sub, cin, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );
`endif
endinterface

// File: rtl/pipelined_addsub.sv
// Chunked, pipelined add/sub with carry/overflow/zero flags.
// ADDSUB_SATURATE_EN adds op_sat: clamp result on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave io
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (CHUNK < 1 || WIDTH % CHUNK != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             sat_in;
  logic             out_valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;

  assign adv          = ~out_valid_q | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.carry_out = carry_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;

  assign bx = io.op_sub ? ~io.b : io.b;

`ifdef ADDSUB_SATURATE_EN
  assign sat_in = io.op_sat;
`else
  assign sat_in = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CHUNK-1:0]         ca;
    logic [CHUNK-1:0]         cb;
    logic                     ci;
    logic                     vi;
    logic                     si;
    logic [CHUNK:0]           sum;
    logic [(k+1)*CHUNK-1:0]   acc;

    if (k == 0) begin : g_src
      assign ca  = io.a[CHUNK-1:0];
      assign cb  = bx[CHUNK-1:0];
      assign ci  = io.cin;
      assign vi  = io.in_valid;
      assign si  = sat_in;
      assign acc = sum[CHUNK-1:0];
    end else begin : g_src
      assign ca  = g_st[k-1].g_reg.ra_q[CHUNK-1:0];
      assign cb  = g_st[k-1].g_reg.rb_q[CHUNK-1:0];
      assign ci  = g_st[k-1].g_reg.c_q;
      assign vi  = g_st[k-1].g_reg.v_q;
      assign si  = g_st[k-1].g_reg.s_q;
      assign acc = {sum[CHUNK-1:0], g_st[k-1].g_reg.acc_q};
    end

    assign sum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, ci};

    if (k < LAST) begin : g_reg
      // Skew registers keep only the chunks later stages still need.
      localparam int RW = WIDTH - (k + 1) * CHUNK;
      logic                   v_q;
      logic                   c_q;
      logic                   s_q;
      logic [(k+1)*CHUNK-1:0] acc_q;
      logic [RW-1:0]          ra_q;
      logic [RW-1:0]          rb_q;
      logic [RW-1:0]          ra_n;
      logic [RW-1:0]          rb_n;

      if (k == 0) begin : g_rem
        assign ra_n = io.a[WIDTH-1:CHUNK];
        assign rb_n = bx[WIDTH-1:CHUNK];
      end else begin : g_rem
        assign ra_n = g_st[k-1].g_reg.ra_q[RW+CHUNK-1:CHUNK];
        assign rb_n = g_st[k-1].g_reg.rb_q[RW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          s_q   <= 1'b0;
          acc_q <= '0;
          ra_q  <= '0;
          rb_q  <= '0;
        end else if (adv) begin
          v_q   <= vi;
          c_q   <= sum[CHUNK];
          s_q   <= si;
          acc_q <= acc;
          ra_q  <= ra_n;
          rb_q  <= rb_n;
        end
      end
    end else begin : g_fin
      logic             ovf;
      logic [WIDTH-1:0] res;

      assign ovf = (ca[CHUNK-1] == cb[CHUNK-1]) &
                   (acc[WIDTH-1] != ca[CHUNK-1]);

      // Operand sign picks the clamp direction on overflow.
      always_comb begin
        res = acc;
        if (si && ovf) begin
          res = ca[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          carry_q     <= 1'b0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
        end else if (adv) begin
          out_valid_q <= vi;
          result_q    <= res;
          carry_q     <= sum[CHUNK];
          ovf_q       <= ovf;
          zero_q      <= ~|res;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed + random bench for pipelined_addsub (WIDTH=32, CHUNK=8).
// Reference model uses wide signed/unsigned arithmetic on whole words.
module tb_pipelined_addsub;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic cur_sat = 1'b0;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic sub, logic ci, logic sat);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] u;
    longint      s;
    bb  = sub ? ~b : b;
    u   = {1'b0, a} + {1'b0, bb} + {32'd0, ci};
    s   = longint'($signed(a)) + longint'($signed(bb)) + longint'(ci);
    e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.r = u[31:0];
    if (sat && e.v) e.r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.c = u[32];
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] a, logic [31:0] b,
                       logic sub, logic ci, logic sat);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    bus.cin      = ci;
`ifdef ADDSUB_SATURATE_EN
    bus.op_sat   = sat;
    cur_sat      = sat;
`else
    cur_sat      = 1'b0 & sat;
`endif
  endtask

  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk1("stray_beat", bus.out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sb_result", bus.result, e.r);
        chk1("sb_carry", bus.carry_out, e.c);
        chk1("sb_ovf", bus.overflow, e.v);
        chk1("sb_zero", bus.zero, e.z);
      end
    end
    if (acc) q.push_back(model(bus.a, bus.b, bus.op_sub, bus.cin, cur_sat));
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit d;
    tick(d);
  endtask

  task automatic send_lat(string tag, logic [31:0] a, logic [31:0] b,
                          logic sub, logic ci, logic sat,
                          logic [31:0] er, logic ec, logic ev, logic ez);
    bit acc;
    bus.out_ready = 1'b1;
    drive(1'b1, a, b, sub, ci, sat);
    tick(acc);
    chk1({tag, "_acc"}, acc, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk1({tag, "_early"}, bus.out_valid, 1'b0);
      step();
    end
    chk1({tag, "_lat"}, bus.out_valid, 1'b1);
    chk({tag, "_res"}, bus.result, er);
    chk1({tag, "_cy"}, bus.carry_out, ec);
    chk1({tag, "_ov"}, bus.overflow, ev);
    chk1({tag, "_z"}, bus.zero, ez);
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  idx;
    int  st;
    int  handed;
    bit  seen;
    bit  acc;
    logic [31:0] ra;
    logic [31:0] rb;

    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 32'd0);
    chk1("rst_carry", bus.carry_out, 1'b0);
    chk1("rst_ovf", bus.overflow, 1'b0);
    chk1("rst_zero", bus.zero, 1'b0);
    chk1("rst_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    send_lat("t1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_lat("t2a", 32'd8, 32'd4, 1'b1, 1'b1, 1'b0,
             32'h0000_0004, 1'b1, 1'b0, 1'b0);
    send_lat("t2b", 32'd4, 32'd8, 1'b1, 1'b1, 1'b0,
             32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    send_lat("t3a", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_lat("t3b", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0,
             32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Five back-to-back beats with a 3-cycle stall at the first result.
    idx = 1;
    st = 0;
    handed = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && (idx <= 5 || q.size() > 0); cyc++) begin
      drive(idx <= 5, 32'(idx), 32'(idx), 1'b0, 1'b0, 1'b0);
      if (bus.out_valid && !seen) begin
        seen = 1'b1;
        st = 3;
      end
      bus.out_ready = (st == 0);
      #1;
      if (st > 0) begin
        chk1("t4_stall_rdy", bus.in_ready, 1'b0);
        chk1("t4_stall_vld", bus.out_valid, 1'b1);
        chk("t4_stall_res", bus.result, 32'd2);
        st--;
      end else if (seen) begin
        chk1("t4_stream", bus.out_valid, 1'b1);
        handed++;
      end
      tick(acc);
      if (acc) idx++;
    end
    chk("t4_handed", 32'(handed), 32'd5);
    chk("t4_drained", 32'(q.size()), 32'd0);

    // Reset with three beats in flight.
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    bus.out_ready = 1'b0;
    #1;
    chk1("t5_pre_vld", bus.out_valid, 1'b1);
    chk1("t5_pre_zero", bus.zero, 1'b1);
    chk1("t5_pre_cy", bus.carry_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5_rst_vld", bus.out_valid, 1'b0);
    chk("t5_rst_res", bus.result, 32'd0);
    chk1("t5_rst_cy", bus.carry_out, 1'b0);
    chk1("t5_rst_ov", bus.overflow, 1'b0);
    chk1("t5_rst_z", bus.zero, 1'b0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk1("t5_stale", bus.out_valid, 1'b0);
      step();
    end
    send_lat("t5_new", 32'd1, 32'd1, 1'b0, 1'b0, 1'b0,
             32'd2, 1'b0, 1'b0, 1'b0);

`ifdef ADDSUB_SATURATE_EN
    send_lat("t6_sat", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_lat("t6_wrap", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_lat("t6_neg", 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1,
             32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif

    for (int n = 0; n < 400; n++) begin
      ra = pick();
      rb = pick();
      drive($urandom_range(0, 3) != 0, ra, rb,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk1("drain_idle", bus.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
